// File: rtl/motors_pulse_executor.sv
// motors_pulse_executor
//   Executes one pen-plotter move: latches signed X/Y pulse counts and a pen
//   servo position, waits a direction setup time, then emits |x| and |y| step
//   pulses in lockstep (both axes share the same step period; the shorter axis
//   simply stops early) and pulses done once.
//
// Ports
//   clk          system clock, all state on rising edge
//   reset        asynchronous active-low reset
//   pulse_num_x  signed X pulse count (two's complement)
//   pulse_num_y  signed Y pulse count (two's complement)
//   servo_pos    requested pen servo position
//   trigger      command strobe, only looked at while rdy=1
//   rdy          high while idle; a trigger in this cycle is accepted
//   done         one-cycle pulse when a command completes
//   step_x/y     registered stepper pulse lines
//   dir_x/y      latched direction, 1 = negative count
//   servo_out    latched servo position
module motors_pulse_executor #(
  parameter int PULSE_NUM_X_BITS   = 16,
  parameter int PULSE_NUM_Y_BITS   = 16,
  parameter int HALF_PERIOD_CYCLES = 50,
  parameter int DIR_SETUP_CYCLES   = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [PULSE_NUM_X_BITS-1:0] pulse_num_x,
  input  logic [PULSE_NUM_Y_BITS-1:0] pulse_num_y,
  input  logic                        servo_pos,
  input  logic                        trigger,
  output logic                        rdy,
  output logic                        done,
  output logic                        step_x,
  output logic                        step_y,
  output logic                        dir_x,
  output logic                        dir_y,
  output logic                        servo_out
);

  localparam int XB = PULSE_NUM_X_BITS;
  localparam int YB = PULSE_NUM_Y_BITS;
  localparam int HW = (HALF_PERIOD_CYCLES > 1) ? $clog2(HALF_PERIOD_CYCLES) : 1;
  localparam int SW = (DIR_SETUP_CYCLES > 1) ? $clog2(DIR_SETUP_CYCLES) : 1;
  localparam logic [HW-1:0] HALF_LAST  = HW'(HALF_PERIOD_CYCLES - 1);
  localparam logic [SW-1:0] SETUP_LAST = SW'(DIR_SETUP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETUP, RUN, FINISH} state_t;

  state_t        state_reg, state_next;
  logic [XB-1:0] rem_x_reg, rem_x_next;
  logic [YB-1:0] rem_y_reg, rem_y_next;
  logic [HW-1:0] half_cnt_reg, half_cnt_next;
  logic [SW-1:0] setup_cnt_reg, setup_cnt_next;
  logic          phase_reg, phase_next;
  logic          dir_x_reg, dir_x_next;
  logic          dir_y_reg, dir_y_next;
  logic          servo_reg, servo_next;
  logic          step_x_reg, step_x_next;
  logic          step_y_reg, step_y_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      rem_x_reg     <= '0;
      rem_y_reg     <= '0;
      half_cnt_reg  <= '0;
      setup_cnt_reg <= '0;
      phase_reg     <= 1'b0;
      dir_x_reg     <= 1'b0;
      dir_y_reg     <= 1'b0;
      servo_reg     <= 1'b0;
      step_x_reg    <= 1'b0;
      step_y_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      rem_x_reg     <= rem_x_next;
      rem_y_reg     <= rem_y_next;
      half_cnt_reg  <= half_cnt_next;
      setup_cnt_reg <= setup_cnt_next;
      phase_reg     <= phase_next;
      dir_x_reg     <= dir_x_next;
      dir_y_reg     <= dir_y_next;
      servo_reg     <= servo_next;
      step_x_reg    <= step_x_next;
      step_y_reg    <= step_y_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    rem_x_next     = rem_x_reg;
    rem_y_next     = rem_y_reg;
    half_cnt_next  = half_cnt_reg;
    setup_cnt_next = setup_cnt_reg;
    phase_next     = phase_reg;
    dir_x_next     = dir_x_reg;
    dir_y_next     = dir_y_reg;
    servo_next     = servo_reg;

    case (state_reg)
      IDLE: begin
        if (trigger) begin
          // Negation is done at full input width and kept unsigned, so the
          // most negative input maps to 2^(N-1) without overflow.
          rem_x_next     = pulse_num_x[XB-1] ? ({XB{1'b0}} - pulse_num_x) : pulse_num_x;
          rem_y_next     = pulse_num_y[YB-1] ? ({YB{1'b0}} - pulse_num_y) : pulse_num_y;
          dir_x_next     = pulse_num_x[XB-1];
          dir_y_next     = pulse_num_y[YB-1];
          servo_next     = servo_pos;
          setup_cnt_next = '0;
          state_next     = SETUP;
        end
      end
      SETUP: begin
        if (setup_cnt_reg == SETUP_LAST) begin
          half_cnt_next = '0;
          phase_next    = 1'b1;
          state_next    = (rem_x_reg == '0 && rem_y_reg == '0) ? FINISH : RUN;
        end else begin
          setup_cnt_next = setup_cnt_reg + SW'(1);
        end
      end
      RUN: begin
        if (half_cnt_reg == HALF_LAST) begin
          half_cnt_next = '0;
          phase_next    = ~phase_reg;
          // A full step period ends with its low phase: retire one pulse.
          if (!phase_reg) begin
            if (rem_x_reg != '0) rem_x_next = rem_x_reg - XB'(1);
            if (rem_y_reg != '0) rem_y_next = rem_y_reg - YB'(1);
            if (rem_x_next == '0 && rem_y_next == '0) state_next = FINISH;
          end
        end else begin
          half_cnt_next = half_cnt_reg + HW'(1);
        end
      end
      FINISH: state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // Steps are computed from next-state values and registered, so the pin
    // changes exactly at the edge where the phase/count changes.
    step_x_next = (state_next == RUN) && phase_next && (rem_x_next != '0);
    step_y_next = (state_next == RUN) && phase_next && (rem_y_next != '0);
  end

  assign rdy       = (state_reg == IDLE);
  assign done      = (state_reg == FINISH);
  assign step_x    = step_x_reg;
  assign step_y    = step_y_reg;
  assign dir_x     = dir_x_reg;
  assign dir_y     = dir_y_reg;
  assign servo_out = servo_reg;

endmodule

// File: tb/tb_motors_pulse_executor.sv
// Testbench for motors_pulse_executor. The expected output waveform of each
// command is derived arithmetically from the command values (setup length,
// pulse index, half-period position), independent of the design's FSM.
module tb_motors_pulse_executor;

  localparam int H = 2;
  localparam int S = 4;
  localparam int NH = 1;
  localparam int NS = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] px = '0;
  logic [15:0] py = '0;
  logic        spos = 1'b0;
  logic        trig = 1'b0;
  logic        rdy, done, step_x, step_y, dir_x, dir_y, servo_out;

  logic [7:0]  n_px = '0;
  logic [7:0]  n_py = '0;
  logic        n_trig = 1'b0;
  logic        n_rdy, n_done, n_step_x, n_step_y, n_dir_x, n_dir_y, n_servo;

  int checks = 0;
  int errors = 0;
  logic cur_dx = 1'b0, cur_dy = 1'b0, cur_srv = 1'b0;

  always #5 clk = ~clk;

  motors_pulse_executor #(
    .PULSE_NUM_X_BITS(16), .PULSE_NUM_Y_BITS(16),
    .HALF_PERIOD_CYCLES(H), .DIR_SETUP_CYCLES(S)
  ) dut (
    .clk(clk), .reset(rst_n), .pulse_num_x(px), .pulse_num_y(py),
    .servo_pos(spos), .trigger(trig), .rdy(rdy), .done(done),
    .step_x(step_x), .step_y(step_y), .dir_x(dir_x), .dir_y(dir_y),
    .servo_out(servo_out)
  );

  // Narrow instance so the most-negative-input case finishes quickly.
  motors_pulse_executor #(
    .PULSE_NUM_X_BITS(8), .PULSE_NUM_Y_BITS(8),
    .HALF_PERIOD_CYCLES(NH), .DIR_SETUP_CYCLES(NS)
  ) dut_n (
    .clk(clk), .reset(rst_n), .pulse_num_x(n_px), .pulse_num_y(n_py),
    .servo_pos(1'b0), .trigger(n_trig), .rdy(n_rdy), .done(n_done),
    .step_x(n_step_x), .step_y(n_step_y), .dir_x(n_dir_x), .dir_y(n_dir_y),
    .servo_out(n_servo)
  );

  function automatic logic [6:0] obs();
    return {rdy, done, step_x, step_y, dir_x, dir_y, servo_out};
  endfunction

  task automatic chk(input string tag, input int k, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s k=%0d {rdy,done,sx,sy,dx,dy,srv} got=%b exp=%b", tag, k, got, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Starts at a falling edge with the DUT idle. Issues one command and checks
  // every cycle until the DUT is idle again (or until abort_k, where reset is
  // pulsed asynchronously).
  task automatic run_cmd(input string tag, input int x, input int y, input logic srv,
                         input bit busy, input bit hold, input int abort_k);
    int mx, my, mm, len, t;
    logic ex, ey;
    mx  = (x < 0) ? -x : x;
    my  = (y < 0) ? -y : y;
    mm  = (mx > my) ? mx : my;
    len = S + 2 * H * mm + 1;   // cycle index of the done pulse
    trig = 1'b1; px = 16'(x); py = 16'(y); spos = srv;
    chk({tag, "_idle"}, 0, obs(), {1'b1, 1'b0, 2'b00, cur_dx, cur_dy, cur_srv});
    cur_dx = (x < 0); cur_dy = (y < 0); cur_srv = srv;
    for (int k = 1; k <= len + 1; k++) begin
      @(negedge clk);
      t  = k - S - 1;
      ex = (k > S) && (k <= S + 2 * H * mm) && ((t % (2 * H)) < H) && ((t / (2 * H)) < mx);
      ey = (k > S) && (k <= S + 2 * H * mm) && ((t % (2 * H)) < H) && ((t / (2 * H)) < my);
      chk(tag, k, obs(), {(k == len + 1), (k == len), ex, ey, cur_dx, cur_dy, cur_srv});
      if (k == abort_k) begin
        #2 rst_n = 1'b0; trig = 1'b0;
        #1 chk({tag, "_rst_async"}, k, obs(), 7'b1000000);
        cur_dx = 1'b0; cur_dy = 1'b0; cur_srv = 1'b0;
        for (int j = 0; j < 3; j++) begin
          @(negedge clk);
          chk({tag, "_rst_hold"}, j, obs(), 7'b1000000);
        end
        rst_n = 1'b1;
        return;
      end
      if (hold) trig = 1'b1;
      else if (busy && k <= len) begin
        trig = 1'($urandom_range(0, 1)); px = 16'($urandom); py = 16'($urandom);
        spos = 1'($urandom_range(0, 1));
      end else trig = 1'b0;
    end
  endtask

  initial begin
    int cx, cy, nd, donek;
    logic psx, psy;

    // Asynchronous reset before any clock edge.
    #2 rst_n = 1'b0;
    #1 chk("reset_async", 0, obs(), 7'b1000000);
    @(negedge clk);
    @(negedge clk);
    chk("reset_hold", 0, obs(), 7'b1000000);
    rst_n = 1'b1;

    run_cmd("basic", 3, 1, 1'b0, 0, 0, 0);
    run_cmd("zero", 0, 0, 1'b1, 0, 0, 0);
    run_cmd("busy", -2, 4, 1'b1, 1, 0, 0);
    run_cmd("abort", -3, 2, 1'b1, 0, 0, S + 2 * H + 1);   // 2nd step_x high phase
    run_cmd("post_rst", 1, 0, 1'b0, 0, 0, 0);
    run_cmd("min16", -32768, -1, 1'b0, 0, 0, S + 2 * H * 3 + 1);

    for (int i = 0; i < 8; i++)
      run_cmd("rand", int'($urandom_range(0, 10)) - 5, int'($urandom_range(0, 10)) - 5,
              1'($urandom_range(0, 1)), i[0], 0, 0);

    run_cmd("b2b0", 2, -1, 1'b1, 0, 1, 0);
    run_cmd("b2b1", 1, 1, 1'b0, 0, 1, 0);
    run_cmd("b2b2", 0, 0, 1'b1, 0, 0, 0);

    // Most negative 8-bit count on the narrow instance.
    n_trig = 1'b1; n_px = 8'h80; n_py = 8'hFF;
    @(negedge clk);
    n_trig = 1'b0; n_px = 8'h01; n_py = 8'h01;
    chk_int("n_dir", int'({n_dir_x, n_dir_y, n_rdy}), 6);
    cx = 0; cy = 0; nd = 0; donek = -1; psx = 1'b0; psy = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      if (n_step_x && !psx) cx++;
      if (n_step_y && !psy) cy++;
      if (n_done) begin nd++; donek = k; end
      psx = n_step_x; psy = n_step_y;
      @(negedge clk);
    end
    chk_int("n_x_pulses", cx, 128);
    chk_int("n_y_pulses", cy, 1);
    chk_int("n_done_count", nd, 1);
    chk_int("n_done_cycle", donek, NS + 2 * NH * 128 + 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/motors_pulse_executor.md
MOTORS_PULSE_EXECUTOR -- requirements
Module: motors_pulse_executor

Interface
REQ-001 SHALL have parameter PULSE_NUM_X_BITS, default 16: width of the signed X pulse count.
REQ-002 SHALL have parameter PULSE_NUM_Y_BITS, default 16: width of the signed Y pulse count.
REQ-003 SHALL have parameter HALF_PERIOD_CYCLES, default 50: clk cycles per step half-period, >=1.
REQ-004 SHALL have parameter DIR_SETUP_CYCLES, default 4: clk cycles between direction update and first step edge, >=1.
REQ-005 SHALL have one clock and an asynchronous active-low reset: port clk, input, 1, system clock, all state on rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port pulse_num_x, input, PULSE_NUM_X_BITS, signed X pulse count, two's complement.
REQ-008 SHALL have port pulse_num_y, input, PULSE_NUM_Y_BITS, signed Y pulse count.
REQ-009 SHALL have port servo_pos, input, 1, requested pen servo position.
REQ-010 SHALL have port trigger, input, 1, command strobe, sampled only while rdy=1.
REQ-011 SHALL have port rdy, output, 1, high when a command is accepted this cycle.
REQ-012 SHALL have port done, output, 1, one-cycle pulse on command completion.
REQ-013 SHALL have ports step_x and step_y, output, 1 each, stepper pulse lines.
REQ-014 SHALL have ports dir_x and dir_y, output, 1 each, 1 = negative count.
REQ-015 SHALL have port servo_out, output, 1, latched servo position.

Function
REQ-016 SHALL implement states IDLE, SETUP, RUN and FINISH.
REQ-017 In IDLE, rdy SHALL be 1; in all other states, rdy SHALL be 0.
REQ-018 trigger=1 in IDLE SHALL latch on that edge: magnitudes |pulse_num_x| and |pulse_num_y| as unsigned, dir_x/dir_y = sign bits, servo_out = servo_pos; the state SHALL then go to SETUP.
REQ-019 Magnitude registers SHALL be PULSE_NUM_*_BITS wide unsigned, so that the most negative input (e.g. -32768) yields magnitude 32768 with no overflow.
REQ-020 trigger while not in IDLE SHALL be ignored, and SHALL NOT alter latched values or state.
REQ-021 SETUP SHALL last exactly DIR_SETUP_CYCLES cycles with step_x=step_y=0, then go to RUN.
REQ-022 RUN SHALL use a half-period counter 0..HALF_PERIOD_CYCLES-1 and a phase bit (high/low); the phase SHALL toggle when the counter wraps.
REQ-023 On the first RUN cycle, phase SHALL be high.
REQ-024 step_x SHALL equal phase AND (remaining_x != 0); the same rule SHALL apply to step_y.
REQ-025 At the end of each low phase, each nonzero remaining count SHALL decrement by 1.
REQ-026 When both remaining counts are zero after a decrement, the state SHALL go to FINISH.
REQ-027 A command with both magnitudes zero SHALL go SETUP -> FINISH with no step edges.
REQ-028 RUN duration SHALL be 2*HALF_PERIOD_CYCLES*max(|x|,|y|) cycles; the shorter axis SHALL stop pulsing early, with its step held at 0.
REQ-029 FINISH SHALL last one cycle with done=1, then go to IDLE with rdy=1 on the next cycle.
REQ-030 dir_x, dir_y and servo_out SHALL hold their latched values until the next accepted command.
REQ-031 step outputs SHALL be registered and glitch-free.
REQ-032 Each step high phase and each step low phase SHALL last exactly HALF_PERIOD_CYCLES cycles.

Reset
REQ-033 reset=0 SHALL force immediately, regardless of clk: state IDLE, rdy=1, done=0, step_x=step_y=0, dir_x=dir_y=0, servo_out=0, counters and magnitudes 0.
REQ-034 Reset asserted mid-RUN SHALL abort the command with no done pulse.
REQ-035 After reset release, the first command SHALL be accepted on the first rising edge with trigger=1.

Verification
REQ-036 Basic command: H=2, S=4, trigger with x=+3, y=+1 -> rdy low next cycle, dir_x=dir_y=0, first step_x rise 4 cycles later, exactly 3 step_x and 1 step_y pulses each 2 high/2 low, done one cycle after 12 RUN cycles, rdy high the cycle after.
REQ-037 Negative and extreme values: x=-32768, y=-1 -> dir_x=dir_y=1, 32768 step_x pulses, 1 step_y pulse, single done.
REQ-038 Zero command: x=0, y=0, servo_pos=1 -> servo_out=1, no step edges, done exactly S+1 cycles after trigger.
REQ-039 Busy trigger: trigger pulses during RUN with different values -> pulse counts, dir and servo_out unchanged, exactly one done.
REQ-040 Reset mid-RUN: assert reset during 2nd step_x high phase -> all outputs at reset values asynchronously, no done; after release a new x=+1 command completes normally.
REQ-041 Back-to-back: trigger held high continuously -> a new command is accepted in each IDLE cycle, with done pulses separated by command length plus 2 cycles.
